// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer: FSM state encoding and
// the seven-segment glyph table.
package countdown_pkg;

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned KEY_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Active-low {g,f,e,d,c,b,a}; index 15 is the leftmost entry.
    localparam logic [15:0][SEG_W-1:0] SEG_PATTERNS = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/hex7seg.sv
// Hex digit to active-low seven-segment decoder.
module hex7seg
    import countdown_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [SEG_W-1:0]   o_seg_c
);

    assign o_seg_c = SEG_PATTERNS[i_digit];

endmodule

// File: rtl/countdown_timer.sv
// Loadable seconds countdown timer with pause, abort and a blinking done
// indication; count is shown on LEDR and three hex digits.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic              CLOCK_50,
    input  logic [KEY_W-1:0]  KEY,
    input  logic [CNT_W-1:0]  SW,
    output logic [CNT_W-1:0]  LEDR,
    output logic [SEG_W-1:0]  HEX0,
    output logic [SEG_W-1:0]  HEX1,
    output logic [SEG_W-1:0]  HEX2
);

    localparam int unsigned     PRE_W   = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic             w_rst_n;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_prev;
    logic [2:0]       w_press;
    logic             w_load;
    logic             w_start;
    logic             w_abort;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [PRE_W-1:0] r_presc;
    logic [PRE_W-1:0] w_presc_nxt;
    logic             r_blink;
    logic             w_blink_nxt;
    logic             w_wrap;

    assign w_rst_n = KEY[0];

    // Released keys read 1, so reset preloads every flop to the idle level.
    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sync1 <= 3'b111;
            r_sync2 <= 3'b111;
            r_prev  <= 3'b111;
        end else begin
            r_sync1 <= KEY[3:1];
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_press = r_prev & ~r_sync2;
    assign w_load  = w_press[0];
    assign w_start = w_press[1];
    assign w_abort = w_press[2];
    assign w_wrap  = (r_presc == PRE_MAX);

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_presc <= '0;
            r_blink <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_presc <= w_presc_nxt;
            r_blink <= w_blink_nxt;
        end
    end

    // Abort beats load beats start; load is ignored while running.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_presc_nxt = r_presc;
        w_blink_nxt = r_blink;
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
            w_presc_nxt = '0;
            w_blink_nxt = 1'b0;
        end else if (w_load && (r_state != ST_RUN)) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = SW;
            w_presc_nxt = '0;
            w_blink_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start && (r_count != '0)) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_start) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (w_wrap) begin
                        w_presc_nxt = '0;
                        if (r_count != '0) begin
                            w_count_nxt = r_count - CNT_W'(1);
                        end
                        if (r_count <= CNT_W'(1)) begin
                            w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_presc_nxt = r_presc + PRE_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (w_start) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (w_wrap) begin
                        w_presc_nxt = '0;
                        w_blink_nxt = ~r_blink;
                    end else begin
                        w_presc_nxt = r_presc + PRE_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign LEDR = (r_state == ST_DONE) ? {CNT_W{r_blink}} : r_count;

    hex7seg u_hex0 (
        .i_digit (r_count[3:0]),
        .o_seg_c (HEX0)
    );

    hex7seg u_hex1 (
        .i_digit (r_count[7:4]),
        .o_seg_c (HEX1)
    );

    hex7seg u_hex2 (
        .i_digit ({2'b00, r_count[9:8]}),
        .o_seg_c (HEX2)
    );

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer at TICK_DIV=4: hex decode vector
// table plus scoreboarded sequences for run, pause, priority and reset cases.
module tb_countdown_timer;
    import countdown_pkg::*;

    localparam int unsigned TD = 4;
    localparam logic [3:1] M_LOAD  = 3'b001;
    localparam logic [3:1] M_START = 3'b010;
    localparam logic [3:1] M_ABORT = 3'b100;

    logic       clk = 1'b0;
    logic [3:0] key;
    logic [9:0] sw;
    logic [9:0] ledr;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic [6:0] hex2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic [9:0] ledr;
        logic [9:0] cnt;
        state_e     st;
    } exp_t;

    typedef struct {
        logic [9:0] sw;
        logic [6:0] h2;
        logic [6:0] h1;
        logic [6:0] h0;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[7];

    always #5 clk = ~clk;

    countdown_timer #(.TICK_DIV(TD)) dut (
        .CLOCK_50 (clk),
        .KEY      (key),
        .SW       (sw),
        .LEDR     (ledr),
        .HEX0     (hex0),
        .HEX1     (hex1),
        .HEX2     (hex2)
    );

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic expect_out(input string nm, input logic [9:0] l, input logic [9:0] c,
                              input state_e s);
        exp_t e;
        e.name = nm;
        e.ledr = l;
        e.cnt  = c;
        e.st   = s;
        exp_q.push_back(e);
    endtask

    task automatic check_pending();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp({e.name, ".ledr"}, 32'(ledr), 32'(e.ledr));
            cmp({e.name, ".hex0"}, 32'(hex0), 32'(seg(e.cnt[3:0])));
            cmp({e.name, ".hex1"}, 32'(hex1), 32'(seg(e.cnt[7:4])));
            cmp({e.name, ".hex2"}, 32'(hex2), 32'(seg({2'b00, e.cnt[9:8]})));
            cmp({e.name, ".state"}, 32'(dut.r_state), 32'(e.st));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the masked keys low for 'hold' edges; returns after the edge on
    // which the press takes effect (third edge) or after release, if later.
    task automatic press(input logic [3:1] m, input int hold);
        key[3:1] = ~m;
        repeat (hold) tick();
        key[3:1] = 3'b111;
        if (hold < 3) repeat (3 - hold) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] c;
        logic [9:0] l;
        state_e     s;

        vecs[0] = '{10'h2A5, 7'b0100100, 7'b0001000, 7'b0010010};
        vecs[1] = '{10'h3FF, 7'b0110000, 7'b0001110, 7'b0001110};
        vecs[2] = '{10'h1B8, 7'b1111001, 7'b0000011, 7'b0000000};
        vecs[3] = '{10'h0C7, 7'b1000000, 7'b1000110, 7'b1111000};
        vecs[4] = '{10'h36D, 7'b0110000, 7'b0000010, 7'b0100001};
        vecs[5] = '{10'h249, 7'b0100100, 7'b0011001, 7'b0010000};
        vecs[6] = '{10'h1E0, 7'b1111001, 7'b0000110, 7'b1000000};

        key = 4'b1110;
        sw  = '0;

        // Reset state, before and after the first clock edge
        #3;
        expect_out("rst_async", 10'h000, 10'h000, ST_IDLE);
        check_pending();
        tick();
        expect_out("rst_held", 10'h000, 10'h000, ST_IDLE);
        check_pending();
        #4 key[0] = 1'b1;
        tick();
        expect_out("rst_release", 10'h000, 10'h000, ST_IDLE);
        check_pending();
        repeat (3) tick();
        expect_out("no_spurious", 10'h000, 10'h000, ST_IDLE);
        check_pending();

        // Start with a zero count stays idle
        press(M_START, 1);
        expect_out("start_zero", 10'h000, 10'h000, ST_IDLE);
        check_pending();
        repeat (4) tick();
        expect_out("start_zero_later", 10'h000, 10'h000, ST_IDLE);
        check_pending();

        // Hex decode table
        for (int i = 0; i < 7; i++) begin
            sw = vecs[i].sw;
            press(M_LOAD, 1);
            cmp($sformatf("vec%0d.ledr", i), 32'(ledr), 32'(vecs[i].sw));
            cmp($sformatf("vec%0d.hex2", i), 32'(hex2), 32'(vecs[i].h2));
            cmp($sformatf("vec%0d.hex1", i), 32'(hex1), 32'(vecs[i].h1));
            cmp($sformatf("vec%0d.hex0", i), 32'(hex0), 32'(vecs[i].h0));
            cmp($sformatf("vec%0d.state", i), 32'(dut.r_state), 32'(ST_IDLE));
        end

        // Load 0x2A5 then abort
        sw = 10'h2A5;
        press(M_LOAD, 1);
        expect_out("load_2a5", 10'h2A5, 10'h2A5, ST_IDLE);
        check_pending();
        press(M_ABORT, 1);
        expect_out("abort_2a5", 10'h000, 10'h000, ST_IDLE);
        check_pending();

        // Full countdown from 3 into the blinking done state
        sw = 10'd3;
        press(M_LOAD, 1);
        expect_out("load3", 10'd3, 10'd3, ST_IDLE);
        check_pending();
        press(M_START, 1);
        expect_out("run_entry", 10'd3, 10'd3, ST_RUN);
        check_pending();
        for (int i = 1; i <= 24; i++) begin
            tick();
            c = (i <= 12) ? 10'(3 - i / 4) : 10'd0;
            s = (i < 12) ? ST_RUN : ST_DONE;
            if (i < 12) l = c;
            else        l = ((((i - 12) / 4) % 2) != 0) ? 10'h3FF : 10'h000;
            expect_out($sformatf("count3_c%0d", i), l, c, s);
            check_pending();
        end

        // Pause two cycles into a run, hold the key, then resume
        press(M_ABORT, 1);
        expect_out("abort_done", 10'h000, 10'h000, ST_IDLE);
        check_pending();
        sw = 10'd5;
        press(M_LOAD, 1);
        press(M_START, 1);
        expect_out("run5_entry", 10'd5, 10'd5, ST_RUN);
        check_pending();
        press(M_START, 6);
        expect_out("paused", 10'd5, 10'd5, ST_PAUSE);
        check_pending();
        for (int i = 0; i < 20; i++) begin
            tick();
            expect_out($sformatf("pause_c%0d", i), 10'd5, 10'd5, ST_PAUSE);
            check_pending();
        end
        press(M_START, 1);
        expect_out("resume", 10'd5, 10'd5, ST_RUN);
        check_pending();
        tick();
        expect_out("resume_c1", 10'd5, 10'd5, ST_RUN);
        check_pending();
        tick();
        expect_out("resume_c2", 10'd4, 10'd4, ST_RUN);
        check_pending();

        // Load and start together: load wins; load during run is ignored
        press(M_ABORT, 1);
        sw = 10'd7;
        press(M_LOAD | M_START, 1);
        expect_out("load_start", 10'd7, 10'd7, ST_IDLE);
        check_pending();
        repeat (5) tick();
        expect_out("load_start_later", 10'd7, 10'd7, ST_IDLE);
        check_pending();
        press(M_START, 1);
        sw = 10'd9;
        press(M_LOAD, 1);
        expect_out("load_in_run", 10'd7, 10'd7, ST_RUN);
        check_pending();
        tick();
        expect_out("load_in_run_dec", 10'd6, 10'd6, ST_RUN);
        check_pending();

        // Asynchronous reset between clock edges while running
        press(M_ABORT, 1);
        sw = 10'd3;
        press(M_LOAD, 1);
        press(M_START, 1);
        tick();
        tick();
        expect_out("pre_reset", 10'd3, 10'd3, ST_RUN);
        check_pending();
        #1 key[0] = 1'b0;
        #1;
        expect_out("rst_midrun", 10'h000, 10'h000, ST_IDLE);
        check_pending();
        #2 key[0] = 1'b1;
        tick();
        expect_out("rst_mid_release", 10'h000, 10'h000, ST_IDLE);
        check_pending();
        repeat (6) tick();
        expect_out("rst_mid_quiet", 10'h000, 10'h000, ST_IDLE);
        check_pending();
        press(M_START, 1);
        expect_out("rst_mid_start0", 10'h000, 10'h000, ST_IDLE);
        check_pending();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000, giving CLOCK_50 cycles per count step (1 Hz); legal range 2 or more.
REQ-002 SHALL have port CLOCK_50, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port KEY, input, 4 bits, with KEY[0] as the reset: asynchronous and active-low. KEY[1] is load, KEY[2] is start/pause and KEY[3] is abort. All keys read 0 when pressed.
REQ-004 SHALL have port SW, input, 10 bits: load value.
REQ-005 SHALL have port LEDR, output, 10 bits: remaining count, or the blink pattern in DONE.
REQ-006 SHALL have ports HEX0, HEX1 and HEX2, output, 7 bits each, active-low segments {g,f,e,d,c,b,a}. They show the remaining count in hex: HEX0 shows count[3:0], HEX1 shows count[7:4], HEX2 shows {2'b00, count[9:8]}.

Function
REQ-007 SHALL pass each of KEY[3:1] through a 2-flop synchronizer, then a falling-edge detector, giving a 1-cycle press pulse per press. The state effect is registered on the 3rd rising edge counting the first edge that samples the key low (latency 2 edges after that).
REQ-008 SHALL hold a 10-bit count, a prescaler of $clog2(TICK_DIV) bits, a blink flag, and state in {IDLE, RUN, PAUSE, DONE}.
REQ-009 SHALL apply this priority when press pulses coincide: abort, then load, then start.
REQ-010 Abort (any state): count = 0, prescaler = 0, blink = 0, state goes to IDLE.
REQ-011 Load in IDLE, PAUSE or DONE: count = SW, prescaler = 0, blink = 0, state goes to IDLE. Load in RUN is ignored.
REQ-012 Start in IDLE: go to RUN if count != 0, otherwise stay in IDLE with no change.
REQ-013 Start in RUN: go to PAUSE, with prescaler and count frozen.
REQ-014 Start in PAUSE: go to RUN, resuming the frozen prescaler value.
REQ-015 Start in DONE: ignored.
REQ-016 In RUN the prescaler increments every cycle. When it is at TICK_DIV-1 it wraps to 0 and the count decrements on that same edge.
REQ-017 The first decrement SHALL occur exactly TICK_DIV cycles after entering RUN from IDLE.
REQ-018 When a decrement takes the count from 1 to 0, state SHALL go to DONE on the same edge. The count never wraps below 0.
REQ-019 In DONE the prescaler keeps running, and the blink flag toggles at each wrap. The first toggle occurs TICK_DIV cycles after entry.
REQ-020 LEDR SHALL be {10{blink}} in DONE and count in all other states; it is a registered value or a direct decode of registers.
REQ-021 HEX outputs SHALL be a combinational decode of the count register. Digit patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-022 A key held low SHALL produce only one press pulse. Key release SHALL have no effect.

Reset
REQ-023 KEY[0]=0 SHALL asynchronously force: state = IDLE, count = 0, prescaler = 0, blink = 0, and all synchronizer and edge flops to the released (1) value.
REQ-024 While in reset, and immediately after it, LEDR SHALL be 0 and HEX0-HEX2 SHALL be 1000000.
REQ-025 Reset asserted mid-RUN SHALL take effect without waiting for a clock edge.
REQ-026 The first press pulse after reset release SHALL require a genuine 1-to-0 key transition.

Structure
REQ-027 SHALL use a package countdown_pkg holding the state enum type and the 16-entry seven-segment pattern constant.
REQ-028 SHALL instantiate sub-module hex7seg (4-bit in, 7-bit active-low out) three times. Synchronizers and edge detectors stay inline.
REQ-029 Target size is 120-400 lines of RTL. No latches, and a single always_ff for state.

Verification (TICK_DIV=4 unless stated)
REQ-030 Reset, then SW=3, press load, then press start. Required: LEDR is 3, then 2, 1, 0 at 4-cycle intervals, and state is DONE on the edge count reaches 0. After that, LEDR shows 3FF and 000 alternating every 4 cycles.
REQ-031 SW=5: load, start, then press start again 2 cycles after RUN entry, wait 20 cycles, then press start. Required: count stays 5 while paused, and the first decrement occurs 2 cycles after resume.
REQ-032 Reset, press start with count 0. Required: state stays IDLE, LEDR=0.
REQ-033 Load and start pressed in the same cycle with SW=7. Required: count=7, state IDLE. A separate load pressed in RUN with SW=9 is ignored.
REQ-034 SW=0x2A5, load. Required: HEX2=0100100, HEX1=0001000, HEX0=0010010. Then abort: count=0, and all HEX outputs are 1000000.
REQ-035 Assert KEY[0] low mid-RUN, between clock edges. Required: LEDR=0 before the next edge, and after release state is IDLE with no spurious presses.
